// File: rtl/debug_tx_scheduler.sv
// debug_tx_scheduler
// Streams a full debug dump over the UART transmitter. A start pulse produces
// a header byte, then the latched PC, every register-file word and a window of
// data-memory words. Each word is sent MSB-first as four bytes, with only one
// byte in flight at a time (strobe, then wait for the UART done tick).
//
// Ports:
//   clk, reset       single clock, synchronous active-high reset
//   i_start          dump request pulse (ignored while busy)
//   i_pc             PC value, captured on the accepted start
//   o_reg_addr       register-file read address (data returns 1 cycle later)
//   i_reg_data       register-file read data
//   o_mem_addr       data-memory read address (data returns 1 cycle later)
//   i_mem_data       data-memory read data
//   o_tx_data        byte presented to the UART
//   o_tx_start       one-cycle load strobe for o_tx_data
//   i_tx_done_tick   UART finished the current byte
//   o_busy           dump in progress (registered)
//   o_done           one-cycle pulse when the dump completes
module debug_tx_scheduler #(
    parameter int          NB_DATA     = 32,
    parameter int          NB_REG_ADDR = 5,
    parameter int          N_REGS      = 32,
    parameter int          NB_MEM_ADDR = 5,
    parameter int          N_MEM_WORDS = 32,
    parameter logic [7:0]  HEADER      = 8'hA5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_start,
    input  logic [NB_DATA-1:0]     i_pc,
    output logic [NB_REG_ADDR-1:0] o_reg_addr,
    input  logic [NB_DATA-1:0]     i_reg_data,
    output logic [NB_MEM_ADDR-1:0] o_mem_addr,
    input  logic [NB_DATA-1:0]     i_mem_data,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_start,
    input  logic                   i_tx_done_tick,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int MAX_WORDS = (N_REGS > N_MEM_WORDS) ? N_REGS : N_MEM_WORDS;
    // A single-word section still needs a 1-bit index.
    localparam int WIDX_W    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    localparam logic [WIDX_W-1:0] LAST_REG = WIDX_W'(N_REGS - 1);
    localparam logic [WIDX_W-1:0] LAST_MEM = WIDX_W'(N_MEM_WORDS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HDR      = 3'd1;
    localparam logic [2:0] S_HDR_WAIT = 3'd2;
    localparam logic [2:0] S_FETCH    = 3'd3;
    localparam logic [2:0] S_LOAD     = 3'd4;
    localparam logic [2:0] S_SEND     = 3'd5;
    localparam logic [2:0] S_WAIT     = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam logic [1:0] SEC_PC   = 2'd0;
    localparam logic [1:0] SEC_REGS = 2'd1;
    localparam logic [1:0] SEC_MEM  = 2'd2;

    logic [2:0]         state_q,   state_d;
    logic [1:0]         section_q, section_d;
    logic [WIDX_W-1:0]  word_q,    word_d;
    logic [1:0]         byte_q,    byte_d;
    logic [NB_DATA-1:0] pc_q,      pc_d;
    logic [NB_DATA-1:0] shift_q,   shift_d;
    logic               busy_q;

    always_comb begin
        state_d   = state_q;
        section_d = section_q;
        word_d    = word_q;
        byte_d    = byte_q;
        pc_d      = pc_q;
        shift_d   = shift_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    pc_d      = i_pc;
                    section_d = SEC_PC;
                    word_d    = '0;
                    byte_d    = '0;
                    state_d   = S_HDR;
                end
            end
            S_HDR:      state_d = S_HDR_WAIT;
            S_HDR_WAIT: if (i_tx_done_tick) state_d = S_FETCH;
            S_FETCH:    state_d = S_LOAD;
            S_LOAD: begin
                // Read data for the address driven in FETCH is valid now.
                case (section_q)
                    SEC_REGS: shift_d = i_reg_data;
                    SEC_MEM:  shift_d = i_mem_data;
                    default:  shift_d = pc_q;
                endcase
                state_d = S_SEND;
            end
            S_SEND:     state_d = S_WAIT;
            S_WAIT: begin
                if (i_tx_done_tick) begin
                    if (byte_q != 2'd3) begin
                        shift_d = shift_q << 8;
                        byte_d  = byte_q + 2'd1;
                        state_d = S_SEND;
                    end else begin
                        byte_d  = '0;
                        state_d = S_FETCH;
                        case (section_q)
                            SEC_PC: begin
                                section_d = SEC_REGS;
                                word_d    = '0;
                            end
                            SEC_REGS: begin
                                if (word_q == LAST_REG) begin
                                    section_d = SEC_MEM;
                                    word_d    = '0;
                                end else begin
                                    word_d = word_q + 1'b1;
                                end
                            end
                            default: begin
                                if (word_q == LAST_MEM) state_d = S_DONE;
                                else                    word_d  = word_q + 1'b1;
                            end
                        endcase
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            section_q <= SEC_PC;
            word_q    <= '0;
            byte_q    <= '0;
            pc_q      <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            section_q <= section_d;
            word_q    <= word_d;
            byte_q    <= byte_d;
            pc_q      <= pc_d;
            shift_q   <= shift_d;
            busy_q    <= (state_d != S_IDLE);
        end
    end

    // Address is driven in FETCH and held through LOAD; 0 otherwise.
    logic addr_phase;
    assign addr_phase = (state_q == S_FETCH) || (state_q == S_LOAD);

    assign o_reg_addr = (addr_phase && section_q == SEC_REGS) ? NB_REG_ADDR'(word_q) : '0;
    assign o_mem_addr = (addr_phase && section_q == SEC_MEM)  ? NB_MEM_ADDR'(word_q) : '0;

    assign o_tx_start = (state_q == S_HDR) || (state_q == S_SEND);
    assign o_tx_data  = (state_q == S_HDR)  ? HEADER :
                        (state_q == S_SEND) ? shift_q[NB_DATA-1 -: 8] : 8'h00;
    assign o_busy     = busy_q;
    assign o_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_debug_tx_scheduler.sv
// Testbench for debug_tx_scheduler: a default-size instance and an
// N_REGS=1 / N_MEM_WORDS=1 instance, each with register/memory read models and
// a UART model; captured bytes are compared against a queue built from the
// dump format (header, PC, registers, memory, MSB-first).
module tb_debug_tx_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset  = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [31:0] pc     = '0;
    logic [4:0]  reg_addr0, mem_addr0, reg_addr1, mem_addr1;
    logic [31:0] reg_data0, mem_data0, reg_data1, mem_data1;
    logic [7:0]  tx_data0, tx_data1;
    logic        tx_start0, tx_start1, busy0, busy1, done0, done1;
    logic        model_tick0 = 1'b0, model_tick1 = 1'b0, inj_tick = 1'b0;
    logic        tick0, tick1;
    assign tick0 = model_tick0 | inj_tick;
    assign tick1 = model_tick1 | inj_tick;

    logic [31:0] regs [32];
    logic [31:0] mems [32];

    debug_tx_scheduler dut0 (
        .clk(clk), .reset(reset), .i_start(start0), .i_pc(pc),
        .o_reg_addr(reg_addr0), .i_reg_data(reg_data0),
        .o_mem_addr(mem_addr0), .i_mem_data(mem_data0),
        .o_tx_data(tx_data0), .o_tx_start(tx_start0), .i_tx_done_tick(tick0),
        .o_busy(busy0), .o_done(done0)
    );

    debug_tx_scheduler #(.N_REGS(1), .N_MEM_WORDS(1)) dut1 (
        .clk(clk), .reset(reset), .i_start(start1), .i_pc(pc),
        .o_reg_addr(reg_addr1), .i_reg_data(reg_data1),
        .o_mem_addr(mem_addr1), .i_mem_data(mem_data1),
        .o_tx_data(tx_data1), .o_tx_start(tx_start1), .i_tx_done_tick(tick1),
        .o_busy(busy1), .o_done(done1)
    );

    // Synchronous read ports: data one cycle after the address.
    always @(posedge clk) begin
        reg_data0 <= regs[reg_addr0];
        mem_data0 <= mems[mem_addr0];
        reg_data1 <= regs[reg_addr1];
        mem_data1 <= mems[mem_addr1];
    end

    int checks = 0, failures = 0;
    int cyc = 0;
    logic [7:0] cap0[$], cap1[$], exp_q[$];
    int  scyc0[$];
    int  done_cnt0 = 0, done_cnt1 = 0;
    int  delay_mode = 0, delay_fixed = 10;
    bit  extra_en = 0;

    // UART model for dut0: done tick k cycles after each strobe. Optionally
    // injects three spurious ticks after each word's last byte tick.
    initial begin
        int cnt = 0, extra = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            model_tick0 = 1'b0;
            if (reset) begin
                cnt = 0; extra = 0;
            end else begin
                if (extra > 0) begin model_tick0 = 1'b1; extra--; end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        model_tick0 = 1'b1;
                        if (extra_en && ((cap0.size() - 1) % 4 == 0)) extra = 3;
                    end
                end
                if (tx_start0) begin
                    cap0.push_back(tx_data0);
                    scyc0.push_back(cyc);
                    cnt = (delay_mode != 0) ? int'($urandom_range(6, 1)) : delay_fixed;
                end
                if (done0) done_cnt0++;
            end
        end
    end

    // UART model for dut1: fixed 2-cycle turnaround.
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk); #1;
            model_tick1 = 1'b0;
            if (reset) cnt = 0;
            else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) model_tick1 = 1'b1;
                end
                if (tx_start1) begin
                    cap1.push_back(tx_data1);
                    cnt = 2;
                end
                if (done1) done_cnt1++;
            end
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    endtask

    task automatic build_exp(input logic [31:0] p, input int nr, input int nm);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        push_word(p);
        for (int i = 0; i < nr; i++) push_word(regs[i]);
        for (int j = 0; j < nm; j++) push_word(mems[j]);
    endtask

    task automatic clear0();
        cap0.delete(); scyc0.delete(); done_cnt0 = 0;
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 32; i++) begin
            regs[i] = $urandom;
            mems[i] = $urandom;
        end
    endtask

    task automatic wait_done0(input int target, input int maxc, output bit ok);
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            if (done_cnt0 >= target) begin ok = 1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            start0   = 1'($urandom);
            start1   = 1'($urandom);
            pc       = $urandom;
            inj_tick = 1'($urandom);
            step();
        end
        checks++;
        if ({tx_data0, tx_start0, busy0, done0, reg_addr0, mem_addr0} !== '0) begin
            failures++;
            $display("FAIL reset_outputs0: got data=%h start=%b busy=%b done=%b ra=%h ma=%h, want all 0",
                     tx_data0, tx_start0, busy0, done0, reg_addr0, mem_addr0);
        end
        checks++;
        if ({tx_data1, tx_start1, busy1, done1, reg_addr1, mem_addr1} !== '0) begin
            failures++;
            $display("FAIL reset_outputs1: got data=%h start=%b busy=%b done=%b, want all 0",
                     tx_data1, tx_start1, busy1, done1);
        end
        reset = 1'b0; start0 = 1'b0; start1 = 1'b0; inj_tick = 1'b0;
        step();
        clear0();
        inj_tick = 1'b1;
        step();
        inj_tick = 1'b0;
        repeat (5) step();
        checks++;
        if (cap0.size() != 0 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL idle_tick: strobes=%0d busy=%b, want 0 strobes busy=0", cap0.size(), busy0);
        end
    endtask

    task automatic test_full_dump();
        bit ok;
        int bad = 0;
        for (int i = 0; i < 32; i++) begin
            regs[i] = 32'h01010101 * i;
            mems[i] = 32'hF0000000 | i;
        end
        pc = 32'h00400010;
        delay_mode = 0; delay_fixed = 10; extra_en = 0;
        build_exp(pc, 32, 32);
        clear0();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        pc = $urandom;  // must not affect the dump
        checks++;
        if (busy0 !== 1'b1 || tx_start0 !== 1'b1 || tx_data0 !== 8'hA5) begin
            failures++;
            $display("FAIL start_latency: busy=%b strobe=%b data=%h, want 1 1 a5", busy0, tx_start0, tx_data0);
        end
        wait_done0(1, 6000, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL full_timeout: done never seen, strobes=%0d", cap0.size());
        end
        step();
        checks++;
        if (busy0 !== 1'b0) begin
            failures++;
            $display("FAIL busy_fall: busy=%b after done, want 0", busy0);
        end
        repeat (3) step();
        checks++;
        if (cap0.size() != 261) begin
            failures++;
            $display("FAIL full_count: got %0d strobes, want 261", cap0.size());
        end
        for (int i = 0; i < cap0.size() && i < exp_q.size(); i++)
            if (cap0[i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL full_bytes: %0d byte mismatches, want 0", bad);
        end
        checks++;
        if (done_cnt0 != 1) begin
            failures++;
            $display("FAIL full_done: got %0d done pulses, want 1", done_cnt0);
        end
    endtask

    task automatic test_handshake();
        bit ok;
        int bad = 0, badgap = 0;
        randomize_mem();
        pc = $urandom;
        delay_mode = 0; delay_fixed = 1; extra_en = 1;
        build_exp(pc, 32, 32);
        clear0();
        start0 = 1'b1; step(); start0 = 1'b0;
        wait_done0(1, 3000, ok);
        repeat (4) step();
        extra_en = 0;
        checks++;
        if (!ok || cap0.size() != 261) begin
            failures++;
            $display("FAIL hs_count: done=%0b strobes=%0d, want done and 261", ok, cap0.size());
        end
        for (int i = 0; i < cap0.size() && i < exp_q.size(); i++)
            if (cap0[i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hs_bytes: %0d byte mismatches, want 0", bad);
        end
        // Gap after byte i: header or last byte of a word needs FETCH+LOAD.
        for (int i = 0; i + 1 < scyc0.size(); i++)
            if (scyc0[i+1] - scyc0[i] != ((i % 4 == 0) ? 4 : 2)) badgap++;
        checks++;
        if (badgap != 0) begin
            failures++;
            $display("FAIL hs_gaps: %0d strobe gaps wrong, want 0", badgap);
        end
    endtask

    task automatic test_start_while_busy();
        bit ok = 0, pulsed = 0;
        int bad = 0;
        randomize_mem();
        pc = $urandom;
        delay_mode = 1; extra_en = 0;
        build_exp(pc, 32, 32);
        clear0();
        start0 = 1'b1; step(); start0 = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (done_cnt0 > 0) begin ok = 1; break; end
            start0 = (cap0.size() == 30 && !pulsed);
            if (start0) pulsed = 1;
            step();
        end
        start0 = 1'b1;  // lands in the DONE cycle
        step();
        start0 = 1'b0;
        checks++;
        if (!ok || busy0 !== 1'b0 || cap0.size() != 261 || done_cnt0 != 1) begin
            failures++;
            $display("FAIL busy_ignore: done=%0b busy=%b strobes=%0d dones=%0d, want 1 0 261 1",
                     ok, busy0, cap0.size(), done_cnt0);
        end
        step();
        checks++;
        if (busy0 !== 1'b0 || tx_start0 !== 1'b0) begin
            failures++;
            $display("FAIL done_start_queued: busy=%b strobe=%b, want 0 0", busy0, tx_start0);
        end
        pc = $urandom;
        build_exp(pc, 32, 32);
        start0 = 1'b1; step(); start0 = 1'b0;
        checks++;
        if (busy0 !== 1'b1 || tx_start0 !== 1'b1 || tx_data0 !== 8'hA5) begin
            failures++;
            $display("FAIL restart: busy=%b strobe=%b data=%h, want 1 1 a5", busy0, tx_start0, tx_data0);
        end
        wait_done0(2, 5000, ok);
        repeat (2) step();
        for (int i = 0; i < 261 && 261 + i < cap0.size(); i++)
            if (cap0[261+i] !== exp_q[i]) bad++;
        checks++;
        if (!ok || cap0.size() != 522 || bad != 0) begin
            failures++;
            $display("FAIL second_dump: done=%0b strobes=%0d mism=%0d, want 1 522 0", ok, cap0.size(), bad);
        end
    endtask

    task automatic test_reset_mid();
        bit ok = 0;
        int bad = 0;
        randomize_mem();
        pc = $urandom;
        delay_mode = 1; extra_en = 0;
        clear0();
        start0 = 1'b1; step(); start0 = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (cap0.size() >= 50) begin ok = 1; break; end
            step();
        end
        reset = 1'b1; step(); reset = 1'b0;
        checks++;
        if (!ok || busy0 !== 1'b0 || tx_start0 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: reached50=%0b busy=%b strobe=%b, want 1 0 0", ok, busy0, tx_start0);
        end
        repeat (40) step();
        checks++;
        if (cap0.size() != 50 || done_cnt0 != 0) begin
            failures++;
            $display("FAIL after_reset: strobes=%0d dones=%0d, want 50 0", cap0.size(), done_cnt0);
        end
        pc = $urandom;
        build_exp(pc, 32, 32);
        clear0();
        start0 = 1'b1; step(); start0 = 1'b0;
        wait_done0(1, 5000, ok);
        repeat (2) step();
        for (int i = 0; i < cap0.size() && i < exp_q.size(); i++)
            if (cap0[i] !== exp_q[i]) bad++;
        checks++;
        if (!ok || cap0.size() != 261 || bad != 0) begin
            failures++;
            $display("FAIL post_reset_dump: done=%0b strobes=%0d mism=%0d, want 1 261 0", ok, cap0.size(), bad);
        end
    endtask

    task automatic test_corner();
        bit ok = 0;
        int bad = 0;
        randomize_mem();
        pc = $urandom;
        build_exp(pc, 1, 1);
        cap1.delete(); done_cnt1 = 0;
        start1 = 1'b1; step(); start1 = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (done_cnt1 > 0) begin ok = 1; break; end
            step();
        end
        repeat (3) step();
        for (int i = 0; i < cap1.size() && i < exp_q.size(); i++)
            if (cap1[i] !== exp_q[i]) bad++;
        checks++;
        if (!ok || cap1.size() != 13 || bad != 0 || done_cnt1 != 1 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL corner: done=%0b strobes=%0d mism=%0d dones=%0d busy=%b, want 1 13 0 1 0",
                     ok, cap1.size(), bad, done_cnt1, busy1);
        end
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_handshake();
        test_start_while_busy();
        test_reset_mid();
        test_corner();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
